mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequential arbiter that shares the single-port unified memory of the WISC-S15 core between the fetch stage and the memory stage. The memory stage issues LW/SW and CALL/RET stack accesses; fetch issues instruction reads. Each access occupies the memory for MEM_LAT cycles. The arbiter:
- grants the port,
- holds address, data and enables stable for the whole access,
- returns read data with a one-cycle ready pulse,
- produces the stall signals that freeze the pipeline.

## Interface
Parameters:
- MEM_LAT, 4: memory access cycles with stable address; legal range 1..15.
- MAX_D_STREAK, 2: consecutive data grants allowed while fetch waits; legal range 1..7.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request, level; held until if_ready.
- if_addr  in  16  fetch address.
- if_rdata  out  16  fetch data register; updated only on fetch completion.
- if_ready  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request, level (MemRead | MemWrite); held until d_ready.
- d_we  in  1  1 = write (SW, CALL push), 0 = read (LW, RET pop).
- d_addr  in  16  data address.
- d_wdata  in  16  write data.
- d_rdata  out  16  data read register; updated only on data-read completion.
- d_ready  out  1  one-cycle completion pulse for data.
- stall_if  out  1  if_req & ~if_ready (combinational).
- stall_mem  out  1  d_req & ~d_ready (combinational).
- mem_en  out  1  memory port active.
- mem_we  out  1  memory write strobe.
- mem_addr  out  16  latched access address.
- mem_wdata  out  16  latched write data.
- mem_rdata  in  16  memory read data; valid in the final busy cycle.

## Operation
- State machine: IDLE, BUSY, RESP. Internal registers: owner (0 = fetch, 1 = data), cnt (4 bits), streak (3 bits), latched addr/wdata/we.
- IDLE, no request: stay in IDLE; mem_en = 0.
- IDLE, one request: grant it.
- IDLE, both requesting: grant data unless streak == MAX_D_STREAK, in which case grant fetch.
- On any grant:
  - latch address, wdata and we (we is 0 for fetch);
  - cnt <= MEM_LAT-1; next state BUSY.
- Streak update at a grant:
  - fetch grant: streak <= 0;
  - data grant with if_req = 1: streak <= streak+1 (saturating);
  - data grant with if_req = 0: streak <= 0.
- BUSY:
  - mem_en = 1; mem_addr and mem_wdata come from the latches.
  - mem_we = latched we, asserted only when cnt == 0 (the final cycle).
  - cnt > 0: cnt decrements.
  - cnt == 0: a read captures mem_rdata into the owner's rdata register; set the owner's ready flop; next state RESP.
- RESP:
  - owner's ready = 1 for exactly this cycle; mem_en = 0; no grant is made.
  - Next state IDLE.
  - A write completion pulses d_ready and leaves d_rdata unchanged.
- Request inputs are ignored during BUSY; latched values are used. A requester dropping req mid-access does not abort it; the ready pulse still occurs.
- if_ready and d_ready are never high in the same cycle.

## Timing
- Reset (synchronous), applied in any state including mid-BUSY:
  - state IDLE; cnt, streak, owner = 0;
  - if_rdata = d_rdata = 0; if_ready = d_ready = 0;
  - mem_en = mem_we = 0; mem_addr = mem_wdata = 0.
  - An in-flight access is abandoned: no ready pulse, no write strobe.
- Latency, request seen in IDLE cycle t:
  - BUSY spans cycles t+1 .. t+MEM_LAT;
  - ready pulses in cycle t+MEM_LAT+1.
- Back-to-back throughput: one access per MEM_LAT+2 cycles. The earliest new grant is in the IDLE cycle after RESP.
- stall_* are combinational from req and ready. They are deasserted exactly in the ready cycle.
- MEM_LAT = 1: BUSY lasts a single cycle in which mem_we (if a write) and the read capture both occur.

## Test plan
MEM_LAT = 4 and MAX_D_STREAK = 2 unless noted; reset is released before cycle 0.
- **Fetch only:** if_req = 1, if_addr = 0x0010 from cycle 0; memory returns 0xA5A5 → mem_en = 1 with mem_addr = 0x0010 in cycles 1-4; if_ready = 1 and if_rdata = 0xA5A5 in cycle 5; stall_if = 1 in cycles 0-4.
- **Data write:** d_req = 1, d_we = 1, d_addr = 0x8000, d_wdata = 0x1234 in cycle 0 → mem_we = 1 only in cycle 4; d_ready pulses in cycle 5; d_rdata stays 0.
- **Simultaneous requests:** if_req and d_req held continuously, data re-requesting after each ready → grant order data, data, fetch, data, data, fetch; streak never exceeds 2.
- **Request change mid-access:** d_addr changes 0x8000 → 0x9000 in cycle 2 of BUSY → mem_addr stays 0x8000 through the whole access.
- **Reset mid-access:** rst = 1 in cycle 3 of a read → in the next cycle all outputs are 0, no ready pulse follows, and a fresh if_req is granted normally afterwards.
- **MEM_LAT = 1:** a read of 0x0002 returning 0x00FF → mem_en in cycle 1 only; ready and rdata = 0x00FF in cycle 2.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for the WISC-S15 core: shares the unified memory between
// instruction fetch and the memory stage, one MEM_LAT-cycle access at a time.
module mem_arbiter #(
  parameter int MEM_LAT      = 4,
  parameter int MAX_D_STREAK = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_ready,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } acc_t;

  localparam logic [3:0] CNT_INIT   = 4'(MEM_LAT - 1);
  localparam logic [2:0] STREAK_MAX = 3'(MAX_D_STREAK);

  state_t      state, state_nxt;
  acc_t        acc, acc_nxt;
  logic        owner;
  logic [3:0]  cnt;
  logic [2:0]  streak, streak_nxt;
  logic        grant, grant_d, last;

  assign last      = (cnt == 4'd0);
  assign mem_addr  = acc.addr;
  assign mem_wdata = acc.wdata;
  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = d_req & ~d_ready;

  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    grant_d    = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        if (if_req | d_req) begin
          grant     = 1'b1;
          // data wins ties until it has starved fetch for MAX_D_STREAK grants
          grant_d   = d_req & (~if_req | (streak != STREAK_MAX));
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        mem_en = 1'b1;
        mem_we = acc.we & last;
        if (last) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    acc_nxt = grant_d ? '{we: d_we, addr: d_addr, wdata: d_wdata}
                      : '{we: 1'b0, addr: if_addr, wdata: d_wdata};

    if (grant_d && if_req) streak_nxt = (streak == 3'd7) ? streak : streak + 3'd1;
    else                   streak_nxt = 3'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      owner    <= 1'b0;
      cnt      <= 4'd0;
      streak   <= 3'd0;
      if_rdata <= 16'h0;
      d_rdata  <= 16'h0;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
    end else begin
      state    <= state_nxt;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      if (grant) begin
        owner  <= grant_d;
        acc    <= acc_nxt;
        cnt    <= CNT_INIT;
        streak <= streak_nxt;
      end else if (state == BUSY) begin
        if (!last) begin
          cnt <= cnt - 4'd1;
        end else if (owner) begin
          d_ready <= 1'b1;
          if (!acc.we) d_rdata <= mem_rdata;
        end else begin
          if_ready <= 1'b1;
          if_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level model (grant cycle -> busy window -> ready cycle).
module tb_mem_arbiter;

  localparam int LAT  = 4;
  localparam int MAXS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ready, d_ready, stall_if, stall_mem, mem_en, mem_we;

  logic        l1_if_req, l1_d_req, l1_d_we;
  logic [15:0] l1_if_addr, l1_d_addr, l1_d_wdata, l1_mem_rdata;
  logic [15:0] l1_if_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata;
  logic        l1_if_ready, l1_d_ready, l1_stall_if, l1_stall_mem, l1_mem_en, l1_mem_we;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(LAT), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.MEM_LAT(1), .MAX_D_STREAK(MAXS)) dut_l1 (
    .clk(clk), .rst(rst),
    .if_req(l1_if_req), .if_addr(l1_if_addr), .if_rdata(l1_if_rdata), .if_ready(l1_if_ready),
    .d_req(l1_d_req), .d_we(l1_d_we), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
    .d_rdata(l1_d_rdata), .d_ready(l1_d_ready),
    .stall_if(l1_stall_if), .stall_mem(l1_stall_mem),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(l1_mem_rdata)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // transaction model: one outstanding access described by its grant cycle
  bit          m_act = 0;
  int          m_gnt = 0;
  bit          m_own_d, m_we;
  logic [15:0] m_addr = 16'h0, m_wdata = 16'h0;
  int          m_streak = 0;
  logic [15:0] e_if_rdata = 16'h0, e_d_rdata = 16'h0;
  bit          prev_ifr = 0, prev_dr = 0;

  task automatic model_cycle();
    bit busy, fin, rdy, idle, e_ifr, e_dr, gd;
    busy  = m_act && cyc > m_gnt && cyc <= m_gnt + LAT;
    fin   = m_act && cyc == m_gnt + LAT;
    rdy   = m_act && cyc == m_gnt + LAT + 1;
    idle  = !m_act || cyc > m_gnt + LAT + 1;
    e_ifr = rdy && !m_own_d;
    e_dr  = rdy && m_own_d;
    chk("mem_en",    32'(mem_en),    32'(busy));
    chk("mem_we",    32'(mem_we),    32'(fin && m_we));
    chk("mem_addr",  32'(mem_addr),  32'(m_addr));
    if (busy && m_we) chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    chk("if_ready",  32'(if_ready),  32'(e_ifr));
    chk("d_ready",   32'(d_ready),   32'(e_dr));
    chk("stall_if",  32'(stall_if),  32'(if_req && !e_ifr));
    chk("stall_mem", 32'(stall_mem), 32'(d_req && !e_dr));
    chk("if_rdata",  32'(if_rdata),  32'(e_if_rdata));
    chk("d_rdata",   32'(d_rdata),   32'(e_d_rdata));
    prev_ifr = e_ifr;
    prev_dr  = e_dr;
    if (rst) begin
      m_act = 0; m_streak = 0; m_addr = 16'h0; m_wdata = 16'h0;
      e_if_rdata = 16'h0; e_d_rdata = 16'h0;
    end else begin
      if (fin && !m_we) begin
        if (m_own_d) e_d_rdata = mem_rdata;
        else         e_if_rdata = mem_rdata;
      end
      if (idle && (if_req || d_req)) begin
        gd      = d_req && (!if_req || m_streak != MAXS);
        m_act   = 1;
        m_gnt   = cyc;
        m_own_d = gd;
        m_we    = gd && d_we;
        m_addr  = gd ? d_addr : if_addr;
        m_wdata = d_wdata;
        m_streak = (gd && if_req) ? ((m_streak < 7) ? m_streak + 1 : 7) : 0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  logic [5:0] pat;
  int         npulse;

  initial begin
    rst = 1'b1;
    if_req = 0; d_req = 0; d_we = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    l1_if_req = 0; l1_d_req = 0; l1_d_we = 0;
    l1_if_addr = 0; l1_d_addr = 0; l1_d_wdata = 0; l1_mem_rdata = 0;
    @(posedge clk); #1;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_en",  32'(mem_en),   32'(0));
    chk("rst_rdy", 32'({if_ready, d_ready}), 32'(0));

    // fetch-only on main DUT alongside a read then a write on the MEM_LAT=1 instance
    for (int k = 0; k < 8; k++) begin
      if_req = (k <= 5); if_addr = 16'h0010; mem_rdata = 16'hA5A5;
      l1_if_req = (k <= 2); l1_if_addr = 16'h0002; l1_mem_rdata = 16'h00FF;
      l1_d_req = (k >= 4 && k <= 6); l1_d_we = 1'b1; l1_d_addr = 16'h0040; l1_d_wdata = 16'hBEEF;
      #1;
      chk("fo_en",    32'(mem_en),   32'(k >= 1 && k <= 4));
      chk("fo_rdy",   32'(if_ready), 32'(k == 5));
      chk("fo_stall", 32'(stall_if), 32'(k <= 4));
      if (k >= 1 && k <= 4) chk("fo_addr", 32'(mem_addr), 32'h0010);
      if (k == 5) chk("fo_rdata", 32'(if_rdata), 32'hA5A5);
      chk("l1_en",    32'(l1_mem_en),   32'(k == 1 || k == 5));
      chk("l1_we",    32'(l1_mem_we),   32'(k == 5));
      chk("l1_ifrdy", 32'(l1_if_ready), 32'(k == 2));
      chk("l1_drdy",  32'(l1_d_ready),  32'(k == 6));
      if (k == 1) chk("l1_addr",  32'(l1_mem_addr), 32'h0002);
      if (k == 2) chk("l1_rdata", 32'(l1_if_rdata), 32'h00FF);
      step();
    end
    l1_if_req = 0; l1_d_req = 0;

    // data write, address changes in the second busy cycle
    for (int k = 0; k < 8; k++) begin
      d_req = (k <= 5); d_we = 1'b1; d_wdata = 16'h1234;
      d_addr = (k >= 2) ? 16'h9000 : 16'h8000;
      mem_rdata = 16'($urandom);
      #1;
      chk("dw_we",  32'(mem_we),  32'(k == 4));
      chk("dw_rdy", 32'(d_ready), 32'(k == 5));
      if (k >= 1 && k <= 4) chk("dw_addr", 32'(mem_addr), 32'h8000);
      if (k == 5) chk("dw_rdata", 32'(d_rdata), 32'h0);
      step();
    end

    // both requesting continuously: expect D D F D D F
    pat = '0; npulse = 0;
    for (int k = 0; k < 40; k++) begin
      if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
      if_addr = 16'($urandom); d_addr = 16'($urandom); mem_rdata = 16'($urandom);
      #1;
      if ((if_ready || d_ready) && npulse < 6) begin
        pat = {pat[4:0], d_ready};
        npulse++;
      end
      step();
    end
    chk("order", 32'(pat), 32'(6'b110110));
    if_req = 0; d_req = 0;
    for (int k = 0; k < 8; k++) step();

    // reset in the third busy cycle of a fetch, then a fresh fetch
    for (int k = 0; k < 16; k++) begin
      if_req = (k <= 2) || (k >= 10);
      if_addr = (k >= 10) ? 16'h0456 : 16'h0123;
      rst = (k == 3);
      mem_rdata = 16'($urandom);
      #1;
      if (k == 4) begin
        chk("ra_en",    32'(mem_en),    32'(0));
        chk("ra_we",    32'(mem_we),    32'(0));
        chk("ra_addr",  32'(mem_addr),  32'(0));
        chk("ra_wdata", 32'(mem_wdata), 32'(0));
        chk("ra_ifrd",  32'(if_rdata),  32'(0));
        chk("ra_drd",   32'(d_rdata),   32'(0));
      end
      if (k >= 4 && k <= 10) chk("ra_norsp", 32'(if_ready), 32'(0));
      if (k == 15) chk("ra_fresh", 32'(if_ready), 32'(1));
      step();
    end
    rst = 1'b0;

    // randomized traffic with occasional resets, drops and address changes
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (prev_ifr || !if_req) begin
        if_req  = ($urandom_range(0, 99) < 50);
        if_addr = 16'($urandom);
      end else begin
        if ($urandom_range(0, 9) == 0)  if_addr = 16'($urandom);
        if ($urandom_range(0, 29) == 0) if_req = 1'b0;
      end
      if (prev_dr || !d_req) begin
        d_req   = ($urandom_range(0, 99) < 50);
        d_we    = ($urandom_range(0, 1) == 1);
        d_addr  = 16'($urandom);
        d_wdata = 16'($urandom);
      end else begin
        if ($urandom_range(0, 9) == 0)  d_addr = 16'($urandom);
        if ($urandom_range(0, 9) == 0)  d_wdata = 16'($urandom);
        if ($urandom_range(0, 29) == 0) d_req = 1'b0;
      end
      mem_rdata = 16'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
